// File: rtl/spi_rx.sv
// SPI receiver, peripheral side. Samples sclk/cs_n/mosi in the i_clock
// domain, assembles MSB-first words of 1-16 bits and hands each word to the
// consumer with a toggle request/acknowledge handshake.
// Optional feature macro: SPI_RX_SYNC_EN. When it is defined, the pins pass
// through SYNC_STAGES flops. Otherwise the pins must already be synchronous
// to i_clock and are registered once, only for edge detection.
module spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [3:0]  i_data_width,
  input  logic        i_cpol,
  input  logic        i_cpha,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  input  logic        i_data_ack,
  input  logic        i_overrun_clr,
  output logic [15:0] o_data,
  output logic        o_data_req,
  output logic        o_overrun,
  output logic        o_busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_reg, state_next;
  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_prev_reg;
  logic        ack_reg;
  logic        sample_rise_reg;
  logic [4:0]  width_reg;
  logic [4:0]  count_reg;
  logic [15:0] shift_reg;
  logic [15:0] word_mask;
  logic [15:0] shift_in;
  logic [4:0]  width_dec;
  logic        sample_edge;
  logic        word_done;
  logic        pending;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("spi_rx: SYNC_STAGES must be 2 or 3");
  end

`ifdef SPI_RX_SYNC_EN
  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, mosi_sync_reg;

  // Synchronizer chains for the three pins; sclk presets to its idle level.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sclk_sync_reg <= {SYNC_STAGES{i_cpol}};
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], i_sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], i_mosi};
    end
  end

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
`else
  assign sclk_s = i_sclk;
  assign cs_s   = i_cs_n;
  assign mosi_s = i_mosi;
`endif

  // Width 0 encodes a 16-bit word.
  assign width_dec   = (i_data_width == 4'd0) ? 5'd16 : {1'b0, i_data_width};
  assign sample_edge = (sclk_s != sclk_prev_reg) && (sclk_s == sample_rise_reg);
  assign word_done   = (count_reg + 5'd1) == width_reg;
  assign pending     = (o_data_req != ack_reg);
  assign shift_in    = {shift_reg[14:0], mosi_s};

  // Keep only the low width_reg bits of a completed word.
  for (genvar gi = 0; gi < 16; gi++) begin : g_mask
    assign word_mask[gi] = (5'(gi) < width_reg);
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next state follows synchronized chip select; busy reflects ACTIVE.
  always_comb begin
    state_next = state_reg;
    o_busy     = 1'b0;
    case (state_reg)
      IDLE:    if (!cs_s) state_next = ACTIVE;
      ACTIVE: begin
        o_busy = 1'b1;
        if (cs_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift/count datapath, word hand-off and overrun tracking.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sclk_prev_reg   <= i_cpol;
      ack_reg         <= 1'b0;
      sample_rise_reg <= 1'b1;
      width_reg       <= 5'd0;
      count_reg       <= 5'd0;
      shift_reg       <= 16'd0;
      o_data          <= 16'd0;
      o_data_req      <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      ack_reg       <= i_data_ack;
      if (i_overrun_clr) o_overrun <= 1'b0;
      if (state_reg == IDLE) begin
        if (!cs_s) begin
          width_reg       <= width_dec;
          sample_rise_reg <= ~(i_cpol ^ i_cpha);
          count_reg       <= 5'd0;
          shift_reg       <= 16'd0;
        end
      end else begin
        if (sample_edge) begin
          if (word_done) begin
            // A completed word is either handed off or counted as overrun;
            // a set here wins over a same-cycle clear.
            if (!pending) begin
              o_data     <= shift_in & word_mask;
              o_data_req <= ~o_data_req;
            end else begin
              o_overrun  <= 1'b1;
            end
            count_reg       <= 5'd0;
            shift_reg       <= 16'd0;
            width_reg       <= width_dec;
            sample_rise_reg <= ~(i_cpol ^ i_cpha);
          end else begin
            shift_reg <= shift_in;
            count_reg <= count_reg + 5'd1;
          end
        end
        // Deselect drops any partial word after a same-cycle completion.
        if (cs_s) begin
          count_reg <= 5'd0;
          shift_reg <= 16'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: an SPI master model drives words, expected
// words are queued as they are sent and popped when o_data_req toggles.
module tb_spi_rx;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  data_width;
  logic        cpol, cpha, sclk, cs_n, mosi, data_ack, overrun_clr;
  logic [15:0] data;
  logic        data_req, overrun, busy;

  int          checks = 0;
  int          errors = 0;
  int          toggles = 0;
  logic [15:0] exp_q[$];
  logic        exp_req = 1'b0;
  logic        prev_req = 1'b0;

  always #5 clk = ~clk;

  spi_rx #(.SYNC_STAGES(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_data_width(data_width),
    .i_cpol(cpol), .i_cpha(cpha), .i_sclk(sclk), .i_cs_n(cs_n),
    .i_mosi(mosi), .i_data_ack(data_ack), .i_overrun_clr(overrun_clr),
    .o_data(data), .o_data_req(data_req), .o_overrun(overrun), .o_busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every request toggle must match a queued word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = data_req;
      end else if (data_req !== prev_req) begin
        prev_req = data_req;
        toggles++;
        if (exp_q.size() == 0) check("spare_toggle", exp_q.size(), 1);
        else check("word", data, exp_q.pop_front());
      end
    end
  end

  task automatic set_mode(input logic pol, input logic pha, input logic [3:0] w);
    cpol = pol; cpha = pha; data_width = w; sclk = pol;
    tick(6);
  endtask

  task automatic cs_assert();
    cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_release();
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = v[i]; tick(HALF); sclk = ~sclk; tick(HALF); sclk = ~sclk;
      end else begin
        sclk = ~sclk; mosi = v[i]; tick(HALF); sclk = ~sclk; tick(HALF);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] v, input int n, input bit accept);
    if (accept) begin
      exp_q.push_back(v);
      exp_req = ~exp_req;
    end
    send_bits(v, n);
  endtask

  task automatic wait_word();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(1);
    if (exp_q.size() != 0) check("word_timeout", exp_q.size(), 0);
    check("req_level", data_req, exp_req);
  endtask

  task automatic ack();
    data_ack = exp_req;
    tick(3);
  endtask

  initial begin
    int t0;
    #500000;
    $display("FAIL watchdog: time limit hit, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; data_width = 4'd8; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    cs_n = 1'b1; mosi = 1'b0; data_ack = 1'b0; overrun_clr = 1'b0;
    tick(3);
    check("rst_data", data, 0);
    check("rst_req", data_req, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    // 1: mode 0, 8 bits
    t0 = toggles;
    set_mode(1'b0, 1'b0, 4'd8);
    cs_assert();
    check("t1_busy_active", busy, 1);
    send_word(16'h00A5, 8, 1'b1);
    cs_release();
    wait_word();
    check("t1_busy_idle", busy, 0);
    check("t1_overrun", overrun, 0);
    check("t1_toggles", toggles - t0, 1);
    ack();

    // 2: mode 3, 16 bits, back to back under one select
    t0 = toggles;
    set_mode(1'b1, 1'b1, 4'd0);
    cs_assert();
    send_word(16'hBEEF, 16, 1'b1);
    wait_word();
    ack();
    send_word(16'h1234, 16, 1'b1);
    wait_word();
    ack();
    cs_release();
    check("t2_toggles", toggles - t0, 2);

    // 3: overrun when the first word is left unacknowledged
    set_mode(1'b0, 1'b0, 4'd8);
    cs_assert();
    send_word(16'h0011, 8, 1'b1);
    wait_word();
    send_word(16'h0022, 8, 1'b0);
    cs_release();
    tick(4);
    check("t3_overrun_set", overrun, 1);
    check("t3_data_kept", data, 16'h0011);
    overrun_clr = 1'b1; tick(1); overrun_clr = 1'b0; tick(1);
    check("t3_overrun_clr", overrun, 0);
    ack();

    // 4: mode 1, 12 bits, fragment discarded then a full word
    t0 = toggles;
    set_mode(1'b0, 1'b1, 4'd12);
    cs_assert();
    send_bits(16'h0015, 5);
    cs_release();
    tick(4);
    check("t4_no_fragment", toggles - t0, 0);
    check("t4_busy_idle", busy, 0);
    cs_assert();
    send_word(16'h0ABC, 12, 1'b1);
    cs_release();
    wait_word();
    ack();

    // 5: reset in the middle of a word
    set_mode(1'b0, 1'b0, 4'd8);
    cs_assert();
    send_bits(16'h002D, 6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_data", data, 0);
    check("t5_rst_req", data_req, 0);
    check("t5_rst_overrun", overrun, 0);
    check("t5_rst_busy", busy, 0);
    exp_req = 1'b0; data_ack = 1'b0; cs_n = 1'b1; sclk = cpol;
    tick(3);
    rst = 1'b0;
    tick(4);
    cs_assert();
    send_word(16'h003C, 8, 1'b1);
    cs_release();
    wait_word();
    ack();

    // 6: mode 2, single-bit words
    t0 = toggles;
    set_mode(1'b1, 1'b0, 4'd1);
    cs_assert();
    send_word(16'h0001, 1, 1'b1); wait_word(); ack();
    send_word(16'h0000, 1, 1'b1); wait_word(); ack();
    send_word(16'h0001, 1, 1'b1); wait_word(); ack();
    cs_release();
    check("t6_toggles", toggles - t0, 3);
    check("final_overrun", overrun, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
